// File: rtl/pow2_div_pkg.sv
// Shared types for the signed power-of-two divide sequencer.
package pow2_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_ASR = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

endpackage

// File: rtl/arith_shift_right_by_one.sv
// Single-step arithmetic right shift; exposes the bit that falls off the LSB.
module arith_shift_right_by_one #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  output logic signed [W-1:0] y,
  output logic                shifted_out
);

  assign y           = {a[W-1], a[W-1:1]};
  assign shifted_out = a[0];

endmodule

// File: rtl/signed_pow2_divide_sequencer.sv
// Multi-cycle signed shift / divide-by-2**S controller around a 1-bit ASR stage,
// with valid/ready handshakes on both sides and one operation in flight.
module signed_pow2_divide_sequencer #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_a,
  input  logic        [SW-1:0] in_s,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_res,
  output logic                busy
);
  import pow2_div_pkg::*;

  localparam logic [SW-1:0] S_MAX      = SW'(W - 1);
  localparam bit            NEED_CLAMP = ((1 << SW) - 1) > (W - 1);

  state_t              state, state_nxt;
  logic [SW-1:0]       cnt;
  logic [SW-1:0]       s_lim;
  mode_t               mode;
  logic signed [W-1:0] acc;
  logic signed [W-1:0] acc_shr;
  logic                shr_bit;
  logic                sticky;
  logic                accept;
  logic                shifting;

  // A negative value that lost set bits sits strictly between two integers;
  // stepping up by one converts the floor result into a toward-zero result.
  function automatic logic signed [W-1:0] round_result(
    input logic signed [W-1:0] a,
    input logic                stk,
    input mode_t               m
  );
    if (m == MODE_DIV && a[W-1] && stk)
      return a + W'(1);
    return a;
  endfunction

  if (NEED_CLAMP) begin : g_clamp
    assign s_lim = (in_s > S_MAX) ? S_MAX : in_s;
  end else begin : g_noclamp
    assign s_lim = in_s;
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign shifting  = (state == SHIFT) && (cnt != '0);

  arith_shift_right_by_one #(.W(W)) u_asr (
    .a           (acc),
    .y           (acc_shr),
    .shifted_out (shr_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = SHIFT;
      SHIFT:   if (cnt == '0)  state_nxt = ROUND;
      ROUND:                   state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Control registers: shift counter, mode, and the visible result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mode    <= MODE_ASR;
      out_res <= '0;
    end else begin
      if (accept) begin
        cnt  <= s_lim;
        mode <= mode_t'(in_mode);
      end else if (shifting) begin
        cnt <= cnt - SW'(1);
      end
      if (state == ROUND)
        out_res <= round_result(acc, sticky, mode);
    end
  end

  // Datapath registers: accumulator and sticky bit carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc    <= in_a;
      sticky <= 1'b0;
    end else if (shifting) begin
      acc    <= acc_shr;
      sticky <= sticky | shr_bit;
    end else if (state == ROUND) begin
      acc    <= round_result(acc, sticky, mode);
    end
  end

endmodule

// File: tb/tb_signed_pow2_divide_sequencer.sv
// Directed bench for signed_pow2_divide_sequencer at W=8.
module tb_signed_pow2_divide_sequencer;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [SW-1:0] in_s;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int n_ops    = 0;

  signed_pow2_divide_sequencer #(.W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_s      (in_s),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && out_valid && out_ready) n_xfer++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic start_op(input logic [W-1:0] a, input int s, input logic m);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_s     = s[SW-1:0];
    in_mode  = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] exp, input int stall);
    check({tag, "_res"}, out_res, exp);
    check({tag, "_inrdy_done"}, in_ready, 1'b0);
    repeat (stall) @(negedge clk);
    if (stall > 0) check({tag, "_res_held"}, out_res, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_vld_clear"}, out_valid, 1'b0);
    n_ops++;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input int s, input logic m,
                        input logic [W-1:0] exp, input int exp_lat, input int stall);
    int lat;
    start_op(a, s, m);
    wait_valid(lat);
    if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
    finish_op(tag, exp, stall);
  endtask

  initial begin
    int lat;
    int ai, ex, s, stall;
    logic [W-1:0] a;
    logic m;
    logic [W-1:0] ex8;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_s = '0; in_mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_res", out_res, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    run_op("p100_s3_m0", 8'd100, 3, 1'b0, 8'h0C, 5, 0);
    run_op("m7_s1_m0",   8'hF9,  1, 1'b0, 8'hFC, 3, 1);
    run_op("m7_s1_m1",   8'hF9,  1, 1'b1, 8'hFD, 3, 0);
    run_op("m1_s7_m0",   8'hFF,  7, 1'b0, 8'hFF, 9, 0);
    run_op("m1_s7_m1",   8'hFF,  7, 1'b1, 8'h00, 9, 2);
    run_op("m128_s7_m0", 8'h80,  7, 1'b0, 8'hFF, 9, 0);
    run_op("m128_s7_m1", 8'h80,  7, 1'b1, 8'hFF, 9, 0);
    run_op("m128_s3_m1", 8'h80,  3, 1'b1, 8'hF0, 5, 0);
    run_op("m9_s2_m1",   8'hF7,  2, 1'b1, 8'hFE, 4, 0);
    run_op("m9_s2_m0",   8'hF7,  2, 1'b0, 8'hFD, 4, 0);

    // S=0 with a long downstream stall and spurious upstream offers.
    start_op(8'hFB, 0, 1'b1);
    wait_valid(lat);
    check("s0_lat", lat, 2);
    check("s0_res", out_res, 8'hFB);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = 8'h55; in_s = 3'd1; in_mode = 1'b0;
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_res", out_res, 8'hFB);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_ops++;
    check("stall_busy_after", busy, 1'b0);
    check("stall_in_ready_after", in_ready, 1'b1);
    run_op("after_stall", 8'd64, 2, 1'b0, 8'h10, 4, 0);

    // Reset in the middle of a shift run abandons the operation.
    start_op(8'd100, 7, 1'b0);
    @(negedge clk);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_res", out_res, 8'h00);
    check("mid_rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    run_op("post_rst", 8'hF9, 1, 1'b1, 8'hFD, 3, 0);

    for (int i = 0; i < 60; i++) begin
      a     = 8'($urandom);
      s     = int'($urandom_range(0, 7));
      m     = 1'($urandom_range(0, 1));
      stall = int'($urandom_range(0, 3));
      ai    = int'($signed(a));
      ex    = m ? (ai / (1 << s)) : (ai >>> s);
      ex8   = ex[W-1:0];
      run_op("rand", a, s, m, ex8, s + 2, stall);
    end

    repeat (2) @(negedge clk);
    check("xfer_count", n_xfer, n_ops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
